// File: rtl/jtag_pkg.sv
// jtag_pkg: TAP state encoding, IEEE 1149.1 transition function and shared JTAG constants
package jtag_pkg;
  localparam int STATE_SIZE = 4;
  localparam int DEF_REGISTER_SIZE = 32;
  localparam int DEF_IR_SIZE = 4;
  localparam logic [DEF_IR_SIZE-1:0] IR_EXTEST = 4'h0;
  localparam logic [DEF_IR_SIZE-1:0] IR_IDCODE = 4'h1;
  localparam logic [DEF_IR_SIZE-1:0] IR_SAMPLE = 4'h2;
  localparam logic [DEF_IR_SIZE-1:0] IR_BYPASS = 4'hF;
  typedef enum logic [STATE_SIZE-1:0] {
    TLR, RTI, SEL_DR, CAP_DR, SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR, UPD_DR,
    SEL_IR, CAP_IR, SHIFT_IR, EXIT1_IR, PAUSE_IR, EXIT2_IR, UPD_IR
  } tap_state_e;
  function automatic tap_state_e tap_next(input tap_state_e s, input logic tms);
    case (s)
      TLR:      tap_next = tms ? TLR      : RTI;
      RTI:      tap_next = tms ? SEL_DR   : RTI;
      SEL_DR:   tap_next = tms ? SEL_IR   : CAP_DR;
      CAP_DR:   tap_next = tms ? EXIT1_DR : SHIFT_DR;
      SHIFT_DR: tap_next = tms ? EXIT1_DR : SHIFT_DR;
      EXIT1_DR: tap_next = tms ? UPD_DR   : PAUSE_DR;
      PAUSE_DR: tap_next = tms ? EXIT2_DR : PAUSE_DR;
      EXIT2_DR: tap_next = tms ? UPD_DR   : SHIFT_DR;
      UPD_DR:   tap_next = tms ? SEL_DR   : RTI;
      SEL_IR:   tap_next = tms ? TLR      : CAP_IR;
      CAP_IR:   tap_next = tms ? EXIT1_IR : SHIFT_IR;
      SHIFT_IR: tap_next = tms ? EXIT1_IR : SHIFT_IR;
      EXIT1_IR: tap_next = tms ? UPD_IR   : PAUSE_IR;
      PAUSE_IR: tap_next = tms ? EXIT2_IR : PAUSE_IR;
      EXIT2_IR: tap_next = tms ? UPD_IR   : SHIFT_IR;
      UPD_IR:   tap_next = tms ? SEL_DR   : RTI;
      default:  tap_next = TLR;
    endcase
  endfunction
endpackage

// File: rtl/jtag_tck_gen.sv
// jtag_tck_gen: TCK divider with rise/fall strobes; once started, a high phase always completes so TCK idles low
module jtag_tck_gen #(
  parameter int TCK_DIV = 2
) (
  input  logic HCLK,
  input  logic HRESETn,
  input  logic en,
  output logic tck,
  output logic tck_rise,
  output logic tck_fall
);
  localparam int DW = TCK_DIV > 1 ? $clog2(TCK_DIV) : 1;
  logic [DW-1:0] div;
  logic act, wrap;
  assign act = en || tck;
  assign wrap = act && div == DW'(TCK_DIV - 1);
  assign tck_rise = wrap && !tck;
  assign tck_fall = wrap && tck;
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      div <= '0;
      tck <= 1'b0;
    end else begin
      div <= (!act || wrap) ? '0 : div + 1'b1;
      if (wrap) tck <= !tck;
    end
endmodule

// File: rtl/jtag_master.sv
// jtag_master: scan sequencer driving a TAP through IR/DR scans, tracking the TAP state on every TCK rise
module jtag_master import jtag_pkg::*; #(
  parameter int REGISTER_SIZE = DEF_REGISTER_SIZE,
  parameter int IR_SIZE = DEF_IR_SIZE,
  parameter int TCK_DIV = 2
) (
  input  logic                     HCLK,
  input  logic                     HRESETn,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_skip_ir,
  input  logic [IR_SIZE-1:0]       cmd_ir,
  input  logic [REGISTER_SIZE-1:0] cmd_dr,
  output logic                     rsp_valid,
  output logic [REGISTER_SIZE-1:0] rsp_data,
  output logic                     TCK,
  output logic                     TMS,
  output logic                     TDI,
  input  logic                     TDO
);
  localparam int MAX_SIZE = REGISTER_SIZE > IR_SIZE ? REGISTER_SIZE : IR_SIZE;
  localparam int CW = $clog2(MAX_SIZE) + 1;
  tap_state_e state, nxt;
  logic busy, ir_pend, tck_rise, tck_fall, tms_d, tdi_d, fire, go, upd;
  logic [2:0] init_cnt;
  logic [CW-1:0] cnt;
  logic [IR_SIZE-1:0] ir_sh;
  logic [REGISTER_SIZE-1:0] dr_sh, cap;
  assign cmd_ready = state == RTI && !busy;
  assign fire = cmd_valid && cmd_ready;
  assign go = busy || fire;
  assign nxt = tap_next(state, TMS);
  assign upd = !TCK || tck_fall;
  jtag_tck_gen #(.TCK_DIV(TCK_DIV)) u_tck (
    .HCLK(HCLK),
    .HRESETn(HRESETn),
    .en(busy || state != RTI),
    .tck(TCK),
    .tck_rise(tck_rise),
    .tck_fall(tck_fall)
  );
  // TMS/TDI to present for the next TCK rise, derived from the TAP state reached by the last rise
  always_comb begin
    tms_d = 1'b0;
    case (state)
      TLR:                         tms_d = init_cnt < 3'd5;
      RTI:                         tms_d = go;
      SEL_DR:                      tms_d = ir_pend;
      SHIFT_IR:                    tms_d = cnt == CW'(IR_SIZE - 1);
      SHIFT_DR:                    tms_d = cnt == CW'(REGISTER_SIZE - 1);
      EXIT1_IR, UPD_IR, EXIT1_DR:  tms_d = 1'b1;
      default:                     tms_d = 1'b0;
    endcase
    tdi_d = state == SHIFT_IR ? ir_sh[0] : state == SHIFT_DR ? dr_sh[0] : 1'b0;
  end
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      state <= TLR;
      busy <= 1'b0;
      ir_pend <= 1'b0;
      init_cnt <= '0;
      cnt <= '0;
      ir_sh <= '0;
      dr_sh <= '0;
      cap <= '0;
      rsp_valid <= 1'b0;
      rsp_data <= '0;
      TMS <= 1'b1;
      TDI <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      if (upd) begin
        TMS <= tms_d;
        TDI <= tdi_d;
      end
      if (fire) begin
        busy <= 1'b1;
        ir_pend <= !cmd_skip_ir;
        ir_sh <= cmd_ir;
        dr_sh <= cmd_dr;
      end
      if (tck_rise) begin
        state <= nxt;
        cnt <= (state == SHIFT_IR || state == SHIFT_DR) ? cnt + 1'b1 : '0;
        if (state == TLR) init_cnt <= init_cnt + 3'd1;
        if (state == SEL_IR) ir_pend <= 1'b0;
        if (state == SHIFT_IR) ir_sh <= ir_sh >> 1;
        if (state == SHIFT_DR) begin
          dr_sh <= dr_sh >> 1;
          cap <= REGISTER_SIZE'({TDO, cap} >> 1);
        end
        if (busy && nxt == RTI) begin
          busy <= 1'b0;
          rsp_valid <= 1'b1;
          rsp_data <= cap;
        end
      end
    end
endmodule

// File: tb/tb_jtag_master.sv
// tb_jtag_master: table-driven and random scans against a behavioural TAP and a queue-based sequence model
module tb_jtag_master;
  localparam int RS = 32, IS = 4, DIV = 2;
  logic HCLK = 0, HRESETn = 1, cmd_valid = 0, cmd_skip_ir = 0, TDO = 0;
  logic [IS-1:0] cmd_ir = '0;
  logic [RS-1:0] cmd_dr = '0;
  logic cmd_ready, rsp_valid, TCK, TMS, TDI;
  logic [RS-1:0] rsp_data;
  int n_tot = 0, n_pass = 0;
  always #5 HCLK = ~HCLK;
  jtag_master #(.REGISTER_SIZE(RS), .IR_SIZE(IS), .TCK_DIV(DIV)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_skip_ir(cmd_skip_ir), .cmd_ir(cmd_ir), .cmd_dr(cmd_dr), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .TCK(TCK), .TMS(TMS), .TDI(TDI), .TDO(TDO)
  );
  // behavioural TAP: 0 TLR,1 RTI,2 SelDR,3 CapDR,4 ShDR,5 Ex1DR,6 PauDR,7 Ex2DR,8 UpdDR,9 SelIR,10 CapIR,11 ShIR,...
  int nx0[16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
  int nx1[16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};
  int tst = 0, tdo_idx = 0, tdi_bad = 0;
  logic [RS-1:0] tdo_word = '0;
  bit tms_q[$], ir_q[$], dr_q[$];
  always @(posedge TCK) begin
    tms_q.push_back(TMS);
    if (tst == 11) ir_q.push_back(TDI);
    else if (tst == 4) dr_q.push_back(TDI);
    else if (TDI !== 1'b0) tdi_bad++;
    tst = TMS ? nx1[tst] : nx0[tst];
  end
  always @(negedge TCK) begin
    if (tst == 3) tdo_idx = 0;
    TDO = (tst == 4 && tdo_idx < RS) ? tdo_word[tdo_idx] : 1'b0;
    if (tst == 4) tdo_idx++;
  end
  int glitch = 0, tck_bad = 0, run = 0, rsp_cnt = 0;
  logic p_tck = 0, p_tms = 1, p_tdi = 0;
  always @(negedge HCLK) begin
    if (rsp_valid) rsp_cnt++;
    if (!HRESETn) run = 0;
    else if (TCK == p_tck) begin
      run++;
      if (TCK && (TMS !== p_tms || TDI !== p_tdi)) glitch++;
    end else begin
      if (p_tck && run != DIV) tck_bad++;
      run = 1;
    end
    p_tck = TCK;
    p_tms = TMS;
    p_tdi = TDI;
  end
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask
  function automatic logic [63:0] pack(input bit q[$], input int s, input int n);
    logic [63:0] v = '0;
    for (int i = 0; i < n && i < 64; i++) if (s + i < q.size()) v[i] = q[s + i];
    return v;
  endfunction
  function automatic logic [63:0] exp_tms(input bit skip, output int n);
    bit e[$];
    e.push_back(1);
    if (!skip) begin
      e.push_back(1); e.push_back(0); e.push_back(0);
      for (int i = 0; i < IS; i++) e.push_back(i == IS - 1);
      e.push_back(1); e.push_back(1);
    end
    e.push_back(0); e.push_back(0);
    for (int i = 0; i < RS; i++) e.push_back(i == RS - 1);
    e.push_back(1); e.push_back(0);
    n = e.size();
    return pack(e, 0, n);
  endfunction
  task automatic wait_ready(input string nm);
    for (int i = 0; i < 400 && !cmd_ready; i++) @(negedge HCLK);
    if (!cmd_ready) chk({nm, " ready_timeout"}, 0, 1);
  endtask
  task automatic wait_rsp(input string nm, output bit ok);
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge HCLK);
      if (rsp_valid) begin ok = 1; break; end
    end
    if (!ok) chk({nm, " rsp_timeout"}, 0, 1);
  endtask
  task automatic check_scan(input string nm, input bit skip, input logic [IS-1:0] ir,
                            input logic [RS-1:0] dr, input logic [RS-1:0] tdo,
                            input int exp_rises, input int ts, input int is, input int ds);
    int n;
    logic [63:0] e;
    e = exp_tms(skip, n);
    chk({nm, " ready_at_rsp"}, cmd_ready, 1);
    chk({nm, " rsp_data"}, rsp_data, tdo);
    chk({nm, " rises"}, tms_q.size() - ts, exp_rises);
    chk({nm, " tms_seq"}, pack(tms_q, ts, n), e);
    chk({nm, " ir_len"}, ir_q.size() - is, skip ? 0 : IS);
    chk({nm, " ir_tdi"}, pack(ir_q, is, IS), skip ? '0 : ir);
    chk({nm, " dr_tdi"}, pack(dr_q, ds, RS), dr);
  endtask
  task automatic run_scan(input string nm, input bit skip, input logic [IS-1:0] ir,
                          input logic [RS-1:0] dr, input logic [RS-1:0] tdo, input int exp_rises);
    bit ok;
    int ts, is, ds;
    wait_ready(nm);
    tdo_word = tdo;
    ts = tms_q.size(); is = ir_q.size(); ds = dr_q.size();
    cmd_valid = 1; cmd_skip_ir = skip; cmd_ir = ir; cmd_dr = dr;
    @(posedge HCLK);
    #1;
    cmd_valid = 0; cmd_skip_ir = !skip; cmd_ir = IS'($urandom); cmd_dr = $urandom;
    wait_rsp(nm, ok);
    if (ok) begin
      check_scan(nm, skip, ir, dr, tdo, exp_rises, ts, is, ds);
      @(negedge HCLK);
      chk({nm, " rsp_pulse"}, rsp_valid, 0);
    end
  endtask
  task automatic check_init(input string nm, input int base);
    int cyc = 0;
    while (!cmd_ready && cyc < 400) begin
      @(negedge HCLK);
      cyc++;
    end
    chk({nm, " ready"}, cmd_ready, 1);
    chk({nm, " cycles_le_24"}, cyc <= 24, 1);
    chk({nm, " rises"}, tms_q.size() - base, 6);
    chk({nm, " tms"}, pack(tms_q, base, 6), 64'h1F);
    chk({nm, " tap_rti"}, tst, 1);
  endtask
  typedef struct {
    bit skip;
    logic [IS-1:0] ir;
    logic [RS-1:0] dr;
    logic [RS-1:0] tdo;
    int rises;
  } vec_t;
  vec_t tv[4];
  initial begin
    bit ok, rs;
    logic [IS-1:0] ri;
    logic [RS-1:0] rd, rt;
    int ts, is, ds, rc, early;
    tv[0] = '{0, 4'h2, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 46};
    tv[1] = '{1, 4'h0, 32'hA5A5_0F0F, 32'h1357_9BDF, 37};
    tv[2] = '{0, 4'hF, 32'h0000_0000, 32'hFFFF_FFFF, 46};
    tv[3] = '{0, 4'h1, 32'h8000_0001, 32'h0000_0000, 46};
    #2 HRESETn = 0;
    repeat (5) @(negedge HCLK);
    chk("reset outputs", {TCK, TMS, TDI, cmd_ready, rsp_valid}, 5'b01000);
    chk("reset rsp_data", rsp_data, 0);
    ts = tms_q.size();
    HRESETn = 1;
    check_init("init", ts);
    foreach (tv[i]) run_scan($sformatf("vec%0d", i), tv[i].skip, tv[i].ir, tv[i].dr, tv[i].tdo, tv[i].rises);
    for (int k = 0; k < 6; k++) begin
      rs = 1'($urandom_range(0, 1)); ri = IS'($urandom); rd = $urandom; rt = $urandom;
      run_scan($sformatf("rand%0d", k), rs, ri, rd, rt, rs ? 37 : 46);
    end
    // back-to-back: cmd_valid stays high, fields swapped to the second command mid-scan
    wait_ready("b2b");
    tdo_word = 32'h0BAD_F00D;
    ts = tms_q.size(); is = ir_q.size(); ds = dr_q.size();
    cmd_valid = 1; cmd_skip_ir = 0; cmd_ir = 4'hA; cmd_dr = 32'h1234_5678;
    @(posedge HCLK);
    #1;
    cmd_skip_ir = 1; cmd_ir = 4'h5; cmd_dr = 32'hCAFE_0001;
    early = 0; ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge HCLK);
      if (rsp_valid) begin ok = 1; break; end
      if (cmd_ready) early++;
    end
    chk("b2b first_rsp_seen", ok, 1);
    chk("b2b ready_while_busy", early, 0);
    check_scan("b2b_a", 0, 4'hA, 32'h1234_5678, 32'h0BAD_F00D, 46, ts, is, ds);
    tdo_word = 32'h7654_3210;
    ts = tms_q.size(); is = ir_q.size(); ds = dr_q.size();
    @(posedge HCLK);
    #1;
    cmd_valid = 0;
    @(negedge HCLK);
    chk("b2b second_accepted", cmd_ready, 0);
    wait_rsp("b2b_b", ok);
    if (ok) check_scan("b2b_b", 1, 4'h5, 32'hCAFE_0001, 32'h7654_3210, 37, ts, is, ds);
    // reset asserted after 10 Shift-DR bits
    wait_ready("abort");
    tdo_word = 32'h1111_2222;
    ds = dr_q.size();
    cmd_valid = 1; cmd_skip_ir = 0; cmd_ir = 4'h3; cmd_dr = 32'h5555_AAAA;
    @(posedge HCLK);
    #1;
    cmd_valid = 0;
    for (int i = 0; i < 3000 && dr_q.size() - ds < 10; i++) @(negedge HCLK);
    chk("abort reached_bit10", dr_q.size() - ds, 10);
    rc = rsp_cnt;
    HRESETn = 0;
    #1;
    chk("abort outputs", {TCK, TMS, TDI, cmd_ready, rsp_valid}, 5'b01000);
    chk("abort rsp_data", rsp_data, 0);
    repeat (3) @(negedge HCLK);
    chk("abort held outputs", {TCK, TMS, TDI, cmd_ready, rsp_valid}, 5'b01000);
    ts = tms_q.size();
    HRESETn = 1;
    check_init("reinit", ts);
    chk("abort no_rsp", rsp_cnt - rc, 0);
    run_scan("after_abort", 0, 4'h2, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 46);
    chk("tms_tdi_stable_while_tck_high", glitch, 0);
    chk("tdi_zero_outside_shift", tdi_bad, 0);
    chk("tck_high_phase_len", tck_bad, 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
